uart_rx_byte: RTL

- 8N1 asynchronous serial receiver; the receive end of the team's serial TX path.
- Samples the RX pin with a mid-bit strobe derived from a clock-cycle counter.
- Presents each received byte with a one-cycle valid pulse, and flags framing errors.
- Sits between the board RX pin and byte consumers such as message checkers and echo logic.

---
 rtl/uart_rx_byte.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 asynchronous serial receiver.
// The RX pin is synchronised through two flops. A start bit is qualified at
// mid-bit, and each data and stop bit is then sampled one bit time later.
// Each good byte is presented with a one-cycle o_valid pulse. A low stop bit
// gives a one-cycle o_frame_err pulse, and the receiver then waits for the
// line to return high.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and an o_parity_err output. The byte is still delivered on a
// parity failure.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_WAIT_HIGH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          rx_meta;
  logic          rx_s;
`ifdef UART_RX_PARITY_EN
  logic          parity_q;
`endif

  // Two-flop synchroniser for the asynchronous RX pin; idles high out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the two stages form a real two-flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with bit-time counter, bit index, shift register and
  // registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle, so a branch that sets
      // one to 1 produces exactly a single-cycle pulse.
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= S_START;
            o_busy <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        S_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == LAST) begin
            cnt              <= '0;
            shift_q[bit_idx] <= rx_s;
            bit_idx          <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == LAST) begin
            cnt      <= '0;
            parity_q <= rx_s;
            state    <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        // Return to IDLE at mid stop bit, so a following start edge half a
        // bit later is caught with no idle gap.
        S_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              o_data  <= shift_q;
              o_valid <= 1'b1;
              o_busy  <= 1'b0;
              state   <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              o_parity_err <= ^{shift_q, parity_q};
`endif
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) must not look like a new start bit.
        S_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
